// File: rtl/simon_game_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// simon_game_ctrl_pkg
// Shared definitions for the Simon game controller:
//   - state_t      : FSM state encoding (also visible on the debug state port)
//   - DEF_*_TICKS  : default on / off / timeout durations in game ticks
//   - max_int      : helper used to size the shared tick timer
//   - speedup_on_ticks : per-round on-time when SIMON_SPEEDUP_EN is defined
// -----------------------------------------------------------------------------
package simon_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FILL     = 3'd0,
        ST_SHOW_ON  = 3'd1,
        ST_SHOW_OFF = 3'd2,
        ST_WAIT     = 3'd3,
        ST_CHECK    = 3'd4,
        ST_ERROR    = 3'd5,
        ST_WIN      = 3'd6
    } state_t;

    localparam int DEF_ON_TICKS      = 8;
    localparam int DEF_OFF_TICKS     = 4;
    localparam int DEF_TIMEOUT_TICKS = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // On-time shrinks by one tick per round, never below two ticks.
    function automatic int speedup_on_ticks(input int on_ticks, input int round);
        int t;
        t = on_ticks - (round - 1);
        return (t < 2) ? 2 : t;
    endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// simon_game_ctrl_if
// Groups every non-clock signal of the Simon controller.
//   master : the controller (drives LFSR step, memory write/read address, LEDs,
//            score and debug state; receives LFSR value, memory data, buttons)
//   slave  : the surrounding system (LFSR, sequence memory, button encoder)
// -----------------------------------------------------------------------------
interface simon_game_ctrl_if #(
    parameter int NUM_COLORS = 4,
    parameter int COLOR_W    = 2,
    parameter int ADDR_W     = 4
);
    logic [COLOR_W-1:0]    rnd_val;
    logic                  rnd_enable;
    logic                  write_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [COLOR_W-1:0]    wr_data;
    logic [ADDR_W-1:0]     rd_addr;
    logic [COLOR_W-1:0]    rd_data;
    logic                  btn_valid;
    logic [COLOR_W-1:0]    btn_val;
    logic [NUM_COLORS-1:0] led;
    logic                  error_led;
    logic                  win_led;
    logic [ADDR_W:0]       score;
    logic [2:0]            state;

    modport master (
        input  rnd_val, rd_data, btn_valid, btn_val,
        output rnd_enable, write_en, wr_addr, wr_data, rd_addr,
               led, error_led, win_led, score, state
    );

    modport slave (
        output rnd_val, rd_data, btn_valid, btn_val,
        input  rnd_enable, write_en, wr_addr, wr_data, rd_addr,
               led, error_led, win_led, score, state
    );
endinterface

// File: rtl/simon_tick_timer.sv
// -----------------------------------------------------------------------------
// simon_tick_timer
// Loadable down-counter shared by the on, off and timeout phases.
//   clk_tick   : game tick
//   reset      : asynchronous active-high reset
//   i_load     : first tick of a timed phase; that tick counts as tick 0
//   i_load_val : phase length minus one
//   i_en       : a timed phase is active
//   o_done     : high on the last tick of the phase
// -----------------------------------------------------------------------------
module simon_tick_timer #(
    parameter int W = 7
) (
    input  logic         clk_tick,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            // The load tick itself is already one elapsed tick.
            r_cnt <= (i_load_val == '0) ? '0 : i_load_val - W'(1);
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = i_en & (i_load ? (i_load_val == '0) : (r_cnt == '0));
endmodule

// File: rtl/simon_game_ctrl.sv
// -----------------------------------------------------------------------------
// simon_game_ctrl
// Simon game controller: fills the sequence memory from the LFSR, plays back
// the current round with a blank gap between steps, checks the player's
// presses with a per-press timeout, keeps score and refills after error/win.
//   clk_tick : game tick clock
//   reset    : asynchronous active-high reset (returns to FILL)
//   bus      : simon_game_ctrl_if.master (LFSR, memory, buttons, LEDs, score,
//              debug state)
// Optional build macro SIMON_SPEEDUP_EN: on-time per round becomes
// max(ON_TICKS-(round-1), 2); otherwise ON_TICKS every round.
// -----------------------------------------------------------------------------
module simon_game_ctrl
    import simon_game_ctrl_pkg::*;
#(
    parameter int NUM_COLORS    = 4,
    parameter int COLOR_W       = 2,
    parameter int MAX_LEN       = 16,
    parameter int ADDR_W        = 4,
    parameter int ON_TICKS      = DEF_ON_TICKS,
    parameter int OFF_TICKS     = DEF_OFF_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic              clk_tick,
    input  logic              reset,
    simon_game_ctrl_if.master bus
);
    localparam int TMR_MAX = max_int(max_int(ON_TICKS, 2), max_int(OFF_TICKS, TIMEOUT_TICKS));
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fill_idx;
    logic [ADDR_W:0]     r_round;
    logic [ADDR_W-1:0]   r_step;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W:0]     r_score;
    logic                r_btn_prev;
    logic [COLOR_W-1:0]  r_btn_latch;
    logic                r_tmr_load;
    logic [TMR_W-1:0]    r_tmr_val;

    logic                w_press;
    logic                w_tmr_en;
    logic                w_tmr_done;
    logic                w_fill;
    logic [ADDR_W:0]     w_step_inc;
    logic                w_more_steps;
    logic [TMR_W-1:0]    w_on_first;
    logic [TMR_W-1:0]    w_on_cur;
    logic [TMR_W-1:0]    w_on_next;
    logic [NUM_COLORS-1:0] w_led;

    assign w_press      = bus.btn_valid & ~r_btn_prev;
    assign w_step_inc   = {1'b0, r_step} + (ADDR_W+1)'(1);
    assign w_more_steps = (w_step_inc < r_round);
    assign w_tmr_en     = (r_state == ST_SHOW_ON) || (r_state == ST_SHOW_OFF) || (r_state == ST_WAIT);

`ifdef SIMON_SPEEDUP_EN
    assign w_on_first = TMR_W'(speedup_on_ticks(ON_TICKS, 1) - 1);
    assign w_on_cur   = TMR_W'(speedup_on_ticks(ON_TICKS, int'(r_round)) - 1);
    assign w_on_next  = TMR_W'(speedup_on_ticks(ON_TICKS, int'(r_round) + 1) - 1);
`else
    assign w_on_first = TMR_W'(ON_TICKS - 1);
    assign w_on_cur   = TMR_W'(ON_TICKS - 1);
    assign w_on_next  = TMR_W'(ON_TICKS - 1);
`endif

    simon_tick_timer #(.W(TMR_W)) u_timer (
        .clk_tick   (clk_tick),
        .reset      (reset),
        .i_load     (r_tmr_load),
        .i_load_val (r_tmr_val),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk_tick or posedge reset) begin
        if (reset) begin
            r_state     <= ST_FILL;
            r_fill_idx  <= '0;
            r_round     <= '0;
            r_step      <= '0;
            r_rd_addr   <= '0;
            r_score     <= '0;
            r_btn_prev  <= 1'b0;
            r_btn_latch <= '0;
            r_tmr_load  <= 1'b0;
            r_tmr_val   <= '0;
        end else begin
            r_btn_prev <= bus.btn_valid;
            r_tmr_load <= 1'b0;
            case (r_state)
                ST_FILL: begin
                    if (r_fill_idx == ADDR_W'(MAX_LEN - 1)) begin
                        r_round    <= (ADDR_W+1)'(1);
                        r_step     <= '0;
                        r_rd_addr  <= '0;
                        r_tmr_load <= 1'b1;
                        r_tmr_val  <= w_on_first;
                        r_state    <= ST_SHOW_ON;
                    end else begin
                        r_fill_idx <= r_fill_idx + ADDR_W'(1);
                    end
                end
                ST_SHOW_ON: begin
                    if (w_tmr_done) begin
                        r_tmr_load <= 1'b1;
                        r_tmr_val  <= TMR_W'(OFF_TICKS - 1);
                        r_state    <= ST_SHOW_OFF;
                    end
                end
                ST_SHOW_OFF: begin
                    if (w_tmr_done) begin
                        r_tmr_load <= 1'b1;
                        if (w_more_steps) begin
                            r_step    <= w_step_inc[ADDR_W-1:0];
                            r_rd_addr <= w_step_inc[ADDR_W-1:0];
                            r_tmr_val <= w_on_cur;
                            r_state   <= ST_SHOW_ON;
                        end else begin
                            r_step    <= '0;
                            r_rd_addr <= '0;
                            r_tmr_val <= TMR_W'(TIMEOUT_TICKS - 1);
                            r_state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A press on the timeout tick wins over the timeout.
                    if (w_press) begin
                        r_btn_latch <= bus.btn_val;
                        r_state     <= ST_CHECK;
                    end else if (w_tmr_done) begin
                        r_state <= ST_ERROR;
                    end
                end
                ST_CHECK: begin
                    if (r_btn_latch != bus.rd_data) begin
                        r_state <= ST_ERROR;
                    end else if (w_more_steps) begin
                        r_step     <= w_step_inc[ADDR_W-1:0];
                        r_rd_addr  <= w_step_inc[ADDR_W-1:0];
                        r_tmr_load <= 1'b1;
                        r_tmr_val  <= TMR_W'(TIMEOUT_TICKS - 1);
                        r_state    <= ST_WAIT;
                    end else begin
                        if (r_score < (ADDR_W+1)'(MAX_LEN))
                            r_score <= r_score + (ADDR_W+1)'(1);
                        if (r_round == (ADDR_W+1)'(MAX_LEN)) begin
                            r_state <= ST_WIN;
                        end else begin
                            r_round    <= r_round + (ADDR_W+1)'(1);
                            r_step     <= '0;
                            r_rd_addr  <= '0;
                            r_tmr_load <= 1'b1;
                            r_tmr_val  <= w_on_next;
                            r_state    <= ST_SHOW_ON;
                        end
                    end
                end
                ST_ERROR, ST_WIN: begin
                    if (w_press) begin
                        r_score    <= '0;
                        r_fill_idx <= '0;
                        r_state    <= ST_FILL;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end

    // LED per colour: lit only for an in-range colour during SHOW_ON.
    generate
        for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_led
            assign w_led[gi] = (r_state == ST_SHOW_ON) && (bus.rd_data == COLOR_W'(gi));
        end
    endgenerate

    // Fill strobes are gated by reset so every output reads 0 while it is held.
    assign w_fill         = (r_state == ST_FILL) & ~reset;
    assign bus.write_en   = w_fill;
    assign bus.rnd_enable = w_fill;
    assign bus.wr_addr    = w_fill ? r_fill_idx : '0;
    assign bus.wr_data    = w_fill ? bus.rnd_val : '0;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.led        = w_led;
    assign bus.error_led  = (r_state == ST_ERROR);
    assign bus.win_led    = (r_state == ST_WIN);
    assign bus.score      = r_score;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_simon_game_ctrl.sv
module tb_simon_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    simon_game_ctrl_if #(.NUM_COLORS(4), .COLOR_W(2), .ADDR_W(2)) bus ();

    simon_game_ctrl #(
        .NUM_COLORS(4), .COLOR_W(2), .MAX_LEN(3), .ADDR_W(2),
        .ON_TICKS(3), .OFF_TICKS(2), .TIMEOUT_TICKS(10)
    ) dut (
        .clk_tick (clk),
        .reset    (rst),
        .bus      (bus)
    );

    // LFSR stub (2,0,2 repeating) and zero-latency sequence memory.
    int         stub_idx = 0;
    logic [1:0] mem [0:3] = '{default: 2'd0};
    assign bus.rnd_val = ((stub_idx % 3) == 1) ? 2'd0 : 2'd2;
    assign bus.rd_data = mem[bus.rd_addr];
    always @(posedge clk) begin
        if (bus.write_en) mem[bus.wr_addr] <= bus.wr_data;
        if (bus.rnd_enable) stub_idx <= stub_idx + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One press: held for exactly one tick; returns at the following sample point.
    task automatic press(input logic [1:0] v);
        bus.btn_valid = 1'b1;
        bus.btn_val   = v;
        tick();
        bus.btn_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (bus.state == s) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
        n_checks++; if (bus.write_en !== 1'b0 || bus.rnd_enable !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got we=%b re=%b want 0 0", bus.write_en, bus.rnd_enable); end
        n_checks++; if (bus.led !== 4'b0 || bus.error_led !== 1'b0 || bus.win_led !== 1'b0) begin n_fail++; $display("FAIL reset_leds got led=%b err=%b win=%b want 0", bus.led, bus.error_led, bus.win_led); end
        n_checks++; if (bus.score !== 3'd0 || bus.wr_data !== 2'd0 || bus.wr_addr !== 2'd0) begin n_fail++; $display("FAIL reset_regs got score=%0d wd=%0d wa=%0d want 0", bus.score, bus.wr_data, bus.wr_addr); end
    endtask

    task automatic test_fill();
        logic [1:0] exp_data [0:2];
        exp_data = '{2'd2, 2'd0, 2'd2};
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.write_en !== 1'b1 || bus.rnd_enable !== 1'b1) begin n_fail++; $display("FAIL fill_strobe[%0d] got we=%b re=%b want 1 1", i, bus.write_en, bus.rnd_enable); end
            n_checks++; if (bus.wr_addr !== 2'(i) || bus.wr_data !== exp_data[i]) begin n_fail++; $display("FAIL fill_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, bus.wr_addr, bus.wr_data, i, exp_data[i]); end
            tick();
        end
        n_checks++; if (bus.write_en !== 1'b0 || bus.state !== 3'd1) begin n_fail++; $display("FAIL fill_end got we=%b state=%0d want 0 1", bus.write_en, bus.state); end
        n_checks++; if (stub_idx !== 3) begin n_fail++; $display("FAIL fill_rnd_pulses got %0d want 3", stub_idx); end
    endtask

    task automatic test_show_round1();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.led !== 4'b0100 || bus.state !== 3'd1) begin n_fail++; $display("FAIL r1_on[%0d] got led=%b st=%0d want 0100 1", i, bus.led, bus.state); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.led !== 4'b0000 || bus.state !== 3'd2) begin n_fail++; $display("FAIL r1_off[%0d] got led=%b st=%0d want 0000 2", i, bus.led, bus.state); end
            tick();
        end
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL r1_wait got %0d want 3", bus.state); end
    endtask

    task automatic test_round1_press();
        logic [3:0] exp_led [0:9];
        exp_led = '{4'b0100, 4'b0100, 4'b0100, 4'b0, 4'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0, 4'b0};
        press(2'd2);
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL r1_check got %0d want 4", bus.state); end
        tick();
        n_checks++; if (bus.score !== 3'd1 || bus.state !== 3'd1) begin n_fail++; $display("FAIL r1_score got score=%0d st=%0d want 1 1", bus.score, bus.state); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.led !== exp_led[i]) begin n_fail++; $display("FAIL r2_show[%0d] got %b want %b", i, bus.led, exp_led[i]); end
            tick();
        end
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL r2_wait got %0d want 3", bus.state); end
    endtask

    task automatic test_error();
        press(2'd2);
        tick();
        n_checks++; if (bus.state !== 3'd3 || bus.rd_addr !== 2'd1) begin n_fail++; $display("FAIL err_step got st=%0d ra=%0d want 3 1", bus.state, bus.rd_addr); end
        press(2'd1);
        tick();
        n_checks++; if (bus.state !== 3'd5 || bus.error_led !== 1'b1 || bus.score !== 3'd1) begin n_fail++; $display("FAIL err_enter got st=%0d err=%b score=%0d want 5 1 1", bus.state, bus.error_led, bus.score); end
        press(2'd0);
        n_checks++; if (bus.state !== 3'd0 || bus.error_led !== 1'b0 || bus.score !== 3'd0) begin n_fail++; $display("FAIL err_exit got st=%0d err=%b score=%0d want 0 0 0", bus.state, bus.error_led, bus.score); end
        n_checks++; if (bus.write_en !== 1'b1 || bus.wr_addr !== 2'd0) begin n_fail++; $display("FAIL err_refill got we=%b wa=%0d want 1 0", bus.write_en, bus.wr_addr); end
    endtask

    task automatic test_timeout();
        bit ok;
        wait_state(3'd3, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL to_reach_wait got state=%0d want 3 within 20 ticks", bus.state); end
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL to_wait[%0d] got %0d want 3", k, bus.state); end
            tick();
        end
        n_checks++; if (bus.state !== 3'd5 || bus.error_led !== 1'b1) begin n_fail++; $display("FAIL to_error got st=%0d err=%b want 5 1", bus.state, bus.error_led); end
        press(2'd3);
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL to_exit got %0d want 0", bus.state); end
    endtask

    task automatic test_timeout_edge_press();
        bit ok;
        wait_state(3'd3, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL edge_reach_wait got state=%0d want 3 within 20 ticks", bus.state); end
        repeat (9) tick();
        press(2'd2);
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL edge_press got %0d want 4", bus.state); end
        tick();
        n_checks++; if (bus.state !== 3'd1 || bus.score !== 3'd1) begin n_fail++; $display("FAIL edge_round2 got st=%0d score=%0d want 1 1", bus.state, bus.score); end
    endtask

    task automatic test_ignored_and_hold();
        int n;
        // press during playback: must not disturb the 10-tick round-2 playback
        bus.btn_valid = 1'b1;
        bus.btn_val   = 2'd1;
        tick();
        tick();
        bus.btn_valid = 1'b0;
        n = 2;
        while (bus.state !== 3'd3 && n < 30) begin
            tick();
            n++;
        end
        n_checks++; if (n !== 10 || bus.score !== 3'd1) begin n_fail++; $display("FAIL show_press_ignored got ticks=%0d score=%0d want 10 1", n, bus.score); end
        // long hold counts once
        bus.btn_valid = 1'b1;
        bus.btn_val   = 2'd2;
        tick();
        n_checks++; if (bus.state !== 3'd4) begin n_fail++; $display("FAIL hold_check got %0d want 4", bus.state); end
        tick();
        tick();
        tick();
        n_checks++; if (bus.state !== 3'd3 || bus.rd_addr !== 2'd1) begin n_fail++; $display("FAIL hold_once got st=%0d ra=%0d want 3 1", bus.state, bus.rd_addr); end
        bus.btn_valid = 1'b0;
        tick();
        press(2'd0);
        tick();
        n_checks++; if (bus.state !== 3'd1 || bus.score !== 3'd2) begin n_fail++; $display("FAIL r3_enter got st=%0d score=%0d want 1 2", bus.state, bus.score); end
    endtask

    task automatic test_win();
        bit ok;
        wait_state(3'd3, 40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL win_reach_wait got state=%0d want 3 within 40 ticks", bus.state); end
        press(2'd2);
        tick();
        press(2'd0);
        tick();
        press(2'd2);
        tick();
        n_checks++; if (bus.state !== 3'd6 || bus.win_led !== 1'b1 || bus.error_led !== 1'b0) begin n_fail++; $display("FAIL win_enter got st=%0d win=%b err=%b want 6 1 0", bus.state, bus.win_led, bus.error_led); end
        n_checks++; if (bus.score !== 3'd3) begin n_fail++; $display("FAIL win_score got %0d want 3", bus.score); end
        press(2'd1);
        n_checks++; if (bus.state !== 3'd0 || bus.win_led !== 1'b0 || bus.score !== 3'd0) begin n_fail++; $display("FAIL win_exit got st=%0d win=%b score=%0d want 0 0 0", bus.state, bus.win_led, bus.score); end
    endtask

    task automatic test_reset_mid_show();
        bit ok;
        wait_state(3'd1, 20, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_reach_show got state=%0d want 1 within 20 ticks", bus.state); end
        tick();
        n_checks++; if (bus.led !== 4'b0100) begin n_fail++; $display("FAIL rst_pre_led got %b want 0100", bus.led); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.led !== 4'b0000 || bus.state !== 3'd0 || bus.write_en !== 1'b0) begin n_fail++; $display("FAIL rst_async got led=%b st=%0d we=%b want 0000 0 0", bus.led, bus.state, bus.write_en); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.write_en !== 1'b1 || bus.wr_addr !== 2'd0) begin n_fail++; $display("FAIL rst_refill got we=%b wa=%0d want 1 0", bus.write_en, bus.wr_addr); end
    endtask

    initial begin
        bus.btn_valid = 1'b0;
        bus.btn_val   = 2'd0;
        test_reset();
        test_fill();
        test_show_round1();
        test_round1_press();
        test_error();
        test_timeout();
        test_timeout_edge_press();
        test_ignored_and_hold();
        test_win();
        test_reset_mid_show();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "time limit");
    end
endmodule
